chiplib_pri_queue_sched: RTL and testbench
==========================================

# chiplib_pri_queue_sched

Multi-requester front end and sequencer for `chiplib_pri_queue_mgr`. It round-robin arbitrates `NumReq` valid/ready push streams into one priority queue and presents the queue head as a valid/ready output stream. It enforces every legality rule the queue datapath relies on: no push when full, no pop when empty, and no combined push+pop when the pushed priority exceeds the head priority. It also provides a flush sequence and an occupancy count.

## Interface

**Parameters**
- `NumReq`, 4: number of push requesters (≥1).
- `DataWidth`, 64: payload width.
- `PriorityWidth`, 16: priority width; larger value means higher priority.
- `QueueDepth`, 16: queue entries (≥2).

**Ports**
- `clk`  in  1: clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `req_valid`  in  `[NumReq]`: push request per requester.
- `req_data`  in  `[NumReq][DataWidth]`: push payload.
- `req_pri`  in  `[NumReq][PriorityWidth]`: push priority.
- `req_ready`  out  `[NumReq]`: push accepted this cycle; at most one bit set.
- `out_valid`  out  1: head entry available.
- `out_data`  out  `DataWidth`: head payload.
- `out_pri`  out  `PriorityWidth`: head priority.
- `out_ready`  in  1: consumer takes head.
- `flush_req`  in  1: single-cycle pulse; discard all entries.
- `flush_busy`  out  1: flush in progress.
- `flush_done`  out  1: one-cycle pulse at flush completion.
- `count`  out  `$clog2(QueueDepth+1)`: current occupancy.

## Operation

**State machine: RUN, FLUSH.**
- **RUN:**
  - `out_valid = ~empty`.
  - pop = `out_valid & out_ready`.
  - Arbiter picks the first valid requester at or after `rr_ptr`, giving grant `g`.
  - A push is accepted (`req_ready[g]=1`) iff `req_valid[g] & (~full | pop) & ~(pop & req_pri[g] > out_pri)`.
  - Priority-above-head combined with pop stalls the push for one cycle. The push is retried the next cycle as a push-only.
  - `flush_req` high moves the state to FLUSH at the next edge. A push or pop in that same cycle still completes.
- **FLUSH:**
  - `out_valid=0` and `req_ready=0`.
  - Pops one entry per cycle while `~empty`.
  - When empty, the state moves to RUN and `flush_done` pulses on the following cycle.
  - `flush_req` is ignored while in FLUSH.
- **Round-robin pointer:** on an accepted push, `rr_ptr` becomes `g+1` mod `NumReq`. Otherwise it holds.
- **Requester rule:** `req_valid`, `req_data` and `req_pri` stay stable until `req_ready`.
- **Ordering:** equal priorities leave in FIFO order, because the queue inserts behind equal entries.
- **`count`:**
  - +1 on push only.
  - −1 on pop only (RUN or FLUSH).
  - Unchanged on push+pop.
  - Never exceeds `QueueDepth`.

## Timing

- **Reset values:**
  - `req_ready=0`, `out_valid=0`, `count=0`, `flush_busy=0`, `flush_done=0`.
  - State is RUN and `rr_ptr=0`.
  - `rst` also drives the queue's synchronous reset, so `rst` must be held across ≥2 `clk` edges.
  - All `req_ready` and `out_valid` are forced 0 while `rst` is high.
- **Latency:**
  - A push accepted at edge T is visible at the head (if highest priority) after T.
  - `count` reflects push and pop one cycle after the handshake.
- **Combinational paths:**
  - `req_ready` depends combinationally on `out_ready`, `out_pri` and the queue's `full` flag.
  - `out_*` are registered (queue head).
- **Full queue:** a push with `out_ready=1` and `req_pri ≤ out_pri` is accepted in the same cycle. Otherwise `req_ready=0`.
- **Empty queue:** `out_valid=0`, no pop is issued, and `out_ready` is don't-care.
- **Flush of N entries:**
  - `flush_req` at cycle 0.
  - `flush_busy` is high cycles 1..N+1.
  - Pops occur cycles 1..N.
  - `flush_done` is high in cycle N+2.
  - For N=0, `flush_busy` is high in cycle 1 and `flush_done` in cycle 2.
- **Reset mid-flush:** returns to RUN, with empty queue, `count=0` and no `flush_done` pulse.

## Structure

- Shared package `chiplib_pri_queue_pkg`: `sched_state_e {RUN, FLUSH}` and the `entry_t`-style `{pri, data}` struct parameterised through the module.
- Sub-module `chiplib_rr_arb` (`NumReq`, request vector, advance strobe, one-hot grant).
- Instance `chiplib_pri_queue_mgr`, with `push_valid`/`pop_valid` driven solely by this block.

## Test plan

- Reset, then requesters 0 and 1 push priorities 5 and 9 in consecutive cycles. Required: `out_pri=9` then 5 on consecutive pops, and `count` goes 1, 2, 1, 0.
- All four requesters hold `req_valid` continuously and `out_ready=0`. Required: grants in order 0, 1, 2, 3, 0, …, and `req_ready` stops after `QueueDepth` pushes with `count=QueueDepth`.
- Full queue with head priority 7 and `out_ready=1`. A push with priority 3 is accepted in the same cycle and `count` stays `QueueDepth`. A push with priority 8 stalls one cycle, then is accepted and becomes the head.
- Three pushes at equal priority 4 with data A, B, C. Required: pops return A, B, C.
- Load 5 entries, then pulse `flush_req`. Required: `flush_busy` for 6 cycles, `flush_done` in cycle 7, `count=0`, no `out_valid`, and all `req_ready=0` while busy.
- Assert `rst` asynchronously mid-flush. Required: all outputs 0 immediately, and after reset a single push of priority 1 appears at the head.

Source files
------------

// File: rtl/chiplib_pri_queue_pkg.sv
// Shared types for the priority-queue scheduler slice.
package chiplib_pri_queue_pkg;

  typedef enum logic [0:0] {
    StRun   = 1'b0,
    StFlush = 1'b1
  } sched_state_e;

endpackage

// File: rtl/chiplib_pri_queue_mgr.sv
// Sorted priority queue; slot 0 is always the head. New entries land behind
// equal priorities so ties drain in FIFO order. Caller guarantees legality.
module chiplib_pri_queue_mgr #(
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PriorityWidth = 16,
  parameter int unsigned QueueDepth    = 16,
  localparam int unsigned CntW         = $clog2(QueueDepth + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_valid,
  input  logic [PriorityWidth-1:0] push_pri,
  input  logic [DataWidth-1:0]     push_data,
  input  logic                     pop_valid,
  output logic [PriorityWidth-1:0] head_pri,
  output logic [DataWidth-1:0]     head_data,
  output logic                     full,
  output logic                     empty
);

  typedef struct packed {
    logic [PriorityWidth-1:0] pri;
    logic [DataWidth-1:0]     data;
  } entry_t;

  entry_t [QueueDepth-1:0] mem_q, mem_d, shifted;
  entry_t                  new_e;
  logic [CntW-1:0]         cnt_q, cnt_d, base_cnt, ins_pos;

  always_comb begin
    new_e   = '{pri: push_pri, data: push_data};
    shifted = mem_q;
    if (pop_valid) begin
      for (int i = 0; i < int'(QueueDepth) - 1; i++) begin
        shifted[i] = mem_q[i+1];
      end
    end
    base_cnt = cnt_q - CntW'(pop_valid);
    // Entries are sorted, so the insert slot is the number at or above push_pri.
    ins_pos = '0;
    for (int i = 0; i < int'(QueueDepth); i++) begin
      if (CntW'(i) < base_cnt && shifted[i].pri >= push_pri) begin
        ins_pos = ins_pos + CntW'(1);
      end
    end
    mem_d = shifted;
    if (push_valid) begin
      if (ins_pos == '0) begin
        mem_d[0] = new_e;
      end
      for (int i = 1; i < int'(QueueDepth); i++) begin
        if (CntW'(i) == ins_pos) begin
          mem_d[i] = new_e;
        end else if (CntW'(i) > ins_pos) begin
          mem_d[i] = shifted[i-1];
        end
      end
    end
    cnt_d = base_cnt + CntW'(push_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_pri  = mem_q[0].pri;
  assign head_data = mem_q[0].data;
  assign full      = (cnt_q == CntW'(QueueDepth));
  assign empty     = (cnt_q == '0);

endmodule

// File: rtl/chiplib_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// pointer moves past the winner only when the grant is consumed.
module chiplib_rr_arb #(
  parameter int unsigned NumReq = 4,
  localparam int unsigned PtrW  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] req,
  input  logic              advance,
  output logic [NumReq-1:0] grant
);

  localparam int N = int'(NumReq);

  logic [PtrW-1:0] ptr_q, nxt;

  // Scan from farthest to nearest so the nearest valid requester wins.
  always_comb begin
    grant = '0;
    nxt   = ptr_q;
    for (int k = N - 1; k >= 0; k--) begin
      for (int i = 0; i < N; i++) begin
        if (i == (int'(ptr_q) + k) % N && req[i]) begin
          grant    = '0;
          grant[i] = 1'b1;
          nxt      = PtrW'((i + 1) % N);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (advance) begin
      ptr_q <= nxt;
    end
  end

endmodule

// File: rtl/chiplib_pri_queue_sched.sv
// Arbitrated multi-requester front end for the priority queue, with flush
// sequencing and an occupancy count. Only this block drives queue push/pop.
module chiplib_pri_queue_sched
  import chiplib_pri_queue_pkg::*;
#(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned PriorityWidth = 16,
  parameter int unsigned QueueDepth    = 16,
  localparam int unsigned CntW         = $clog2(QueueDepth + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NumReq-1:0]                     req_valid,
  input  logic [NumReq-1:0][DataWidth-1:0]      req_data,
  input  logic [NumReq-1:0][PriorityWidth-1:0]  req_pri,
  output logic [NumReq-1:0]                     req_ready,
  output logic                                  out_valid,
  output logic [DataWidth-1:0]                  out_data,
  output logic [PriorityWidth-1:0]              out_pri,
  input  logic                                  out_ready,
  input  logic                                  flush_req,
  output logic                                  flush_busy,
  output logic                                  flush_done,
  output logic [CntW-1:0]                       count
);

  sched_state_e             state_q;
  logic                     flush_done_q;
  logic [CntW-1:0]          count_q;
  logic                     full, empty, pop, push;
  logic [NumReq-1:0]        grant;
  logic [DataWidth-1:0]     g_data, head_data;
  logic [PriorityWidth-1:0] g_pri, head_pri;

  chiplib_rr_arb #(
    .NumReq (NumReq)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (push),
    .grant   (grant)
  );

  always_comb begin
    g_data = '0;
    g_pri  = '0;
    for (int i = 0; i < int'(NumReq); i++) begin
      if (grant[i]) begin
        g_data = req_data[i];
        g_pri  = req_pri[i];
      end
    end
  end

  assign out_valid = ~rst & (state_q == StRun) & ~empty;
  assign pop       = (state_q == StFlush) ? ~empty : (out_valid & out_ready);
  // A push may ride along with a pop only if it cannot overtake the departing head.
  assign push      = ~rst & (state_q == StRun) & (|grant) & (~full | pop)
                     & ~(pop & (g_pri > head_pri));
  assign req_ready = grant & {NumReq{push}};

  chiplib_pri_queue_mgr #(
    .DataWidth     (DataWidth),
    .PriorityWidth (PriorityWidth),
    .QueueDepth    (QueueDepth)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push_valid (push),
    .push_pri   (g_pri),
    .push_data  (g_data),
    .pop_valid  (pop),
    .head_pri   (head_pri),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StRun;
      flush_done_q <= 1'b0;
      count_q      <= '0;
    end else begin
      flush_done_q <= 1'b0;
      case (state_q)
        StRun: begin
          if (flush_req) state_q <= StFlush;
        end
        StFlush: begin
          if (empty) begin
            state_q      <= StRun;
            flush_done_q <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
      if (push & ~pop) begin
        count_q <= count_q + CntW'(1);
      end else if (pop & ~push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  assign out_data   = head_data;
  assign out_pri    = head_pri;
  assign flush_busy = (state_q == StFlush);
  assign flush_done = flush_done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_chiplib_pri_queue_sched.sv
// Bench for chiplib_pri_queue_sched: directed table, corner sequences and a
// randomized run against an arrival-ordered queue reference model.
module tb_chiplib_pri_queue_sched;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int PW = 8;
  localparam int QD = 8;

  logic                   clk, rst;
  logic [NR-1:0]          req_valid;
  logic [NR-1:0][DW-1:0]  req_data;
  logic [NR-1:0][PW-1:0]  req_pri;
  logic [NR-1:0]          req_ready;
  logic                   out_valid, out_ready;
  logic [DW-1:0]          out_data;
  logic [PW-1:0]          out_pri;
  logic                   flush_req, flush_busy, flush_done;
  logic [3:0]             count;

  chiplib_pri_queue_sched #(
    .NumReq        (NR),
    .DataWidth     (DW),
    .PriorityWidth (PW),
    .QueueDepth    (QD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_pri    (req_pri),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_pri    (out_pri),
    .out_ready  (out_ready),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .flush_done (flush_done),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [NR-1:0] valid;
    logic [PW-1:0] pri;
    logic [DW-1:0] data;
    logic          oready;
    logic [NR-1:0] exp_ready;
    logic          exp_ovalid;
    logic [PW-1:0] exp_opri;
    logic [DW-1:0] exp_odata;
    logic [3:0]    exp_count;
  } vec_t;

  function automatic vec_t mk(logic [NR-1:0] v, int p, logic [DW-1:0] d, logic o,
                              logic [NR-1:0] er, logic eov, int ep, logic [DW-1:0] ed,
                              int ec);
    vec_t r;
    r.valid = v; r.pri = PW'(p); r.data = d; r.oready = o;
    r.exp_ready = er; r.exp_ovalid = eov; r.exp_opri = PW'(ep); r.exp_odata = ed;
    r.exp_count = 4'(ec);
    return r;
  endfunction

  vec_t tbl[12];

  typedef struct {
    logic [PW-1:0] pri;
    logic [DW-1:0] data;
  } ent_t;

  ent_t mq[$];

  initial begin
    int rr, g, h;
    bit m_fl, m_done, m_pop, acc, nf;
    logic [NR-1:0] rv, e_ready;
    logic [NR-1:0][PW-1:0] rp;
    logic [NR-1:0][DW-1:0] rd;
    ent_t e;

    req_data = '0;
    req_pri  = '0;
    rst = 1'b1;
    req_valid = '1;
    out_ready = 1'b1;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", req_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_count", count, 0);
    chk("reset_flush_busy", flush_busy, 0);
    chk("reset_flush_done", flush_done, 0);
    rst = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;

    // Priority order, then equal-priority FIFO order across requesters 2,3,0.
    tbl[0]  = mk(4'b0001, 5, 16'h0005, 0, 4'b0001, 0, 0, 16'h0, 0);
    tbl[1]  = mk(4'b0010, 9, 16'h0009, 0, 4'b0010, 1, 5, 16'h0005, 1);
    tbl[2]  = mk(4'b0000, 0, 16'h0000, 1, 4'b0000, 1, 9, 16'h0009, 2);
    tbl[3]  = mk(4'b0000, 0, 16'h0000, 1, 4'b0000, 1, 5, 16'h0005, 1);
    tbl[4]  = mk(4'b0000, 0, 16'h0000, 0, 4'b0000, 0, 0, 16'h0, 0);
    tbl[5]  = mk(4'b0100, 4, 16'h00a0, 0, 4'b0100, 0, 0, 16'h0, 0);
    tbl[6]  = mk(4'b1000, 4, 16'h00b0, 0, 4'b1000, 1, 4, 16'h00a0, 1);
    tbl[7]  = mk(4'b0001, 4, 16'h00c0, 0, 4'b0001, 1, 4, 16'h00a0, 2);
    tbl[8]  = mk(4'b0000, 0, 16'h0000, 1, 4'b0000, 1, 4, 16'h00a0, 3);
    tbl[9]  = mk(4'b0000, 0, 16'h0000, 1, 4'b0000, 1, 4, 16'h00b0, 2);
    tbl[10] = mk(4'b0000, 0, 16'h0000, 1, 4'b0000, 1, 4, 16'h00c0, 1);
    tbl[11] = mk(4'b0000, 0, 16'h0000, 0, 4'b0000, 0, 0, 16'h0, 0);

    foreach (tbl[i]) begin
      req_valid = tbl[i].valid;
      req_pri   = {NR{tbl[i].pri}};
      req_data  = {NR{tbl[i].data}};
      out_ready = tbl[i].oready;
      #4;
      chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_ovalid", i), out_valid, tbl[i].exp_ovalid);
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
      if (tbl[i].exp_ovalid) begin
        chk($sformatf("tbl%0d_opri", i), out_pri, tbl[i].exp_opri);
        chk($sformatf("tbl%0d_odata", i), out_data, tbl[i].exp_odata);
      end
      tick();
    end
    req_valid = '0;
    out_ready = 1'b0;

    // Round-robin fill until full.
    reset_dut();
    req_valid = '1;
    req_pri   = {8'd1, 8'd2, 8'd3, 8'd7};
    req_data  = {16'd3, 16'd2, 16'd1, 16'd0};
    for (int k = 0; k < QD + 2; k++) begin
      #4;
      chk($sformatf("rr_grant%0d", k), req_ready, (k < QD) ? (1 << (k % NR)) : 0);
      chk($sformatf("rr_count%0d", k), count, (k < QD) ? k : QD);
      tick();
    end

    // Full queue, head 7: low-priority push rides with the pop.
    req_valid = 4'b0001;
    req_pri[0] = 8'd3;
    req_data[0] = 16'h0333;
    out_ready = 1'b1;
    #4;
    chk("full_low_ready", req_ready, 4'b0001);
    chk("full_head_pri", out_pri, 7);
    tick();
    req_valid = '0;
    out_ready = 1'b0;
    #4;
    chk("full_low_count", count, QD);
    tick();
    // Higher-than-head push stalls while the pop happens, then goes in alone.
    req_valid = 4'b0010;
    req_pri[1] = 8'd8;
    req_data[1] = 16'h0888;
    out_ready = 1'b1;
    #4;
    chk("full_high_stall", req_ready, 0);
    tick();
    out_ready = 1'b0;
    #4;
    chk("full_high_retry", req_ready, 4'b0010);
    chk("full_high_cnt", count, QD - 1);
    tick();
    req_valid = '0;
    #4;
    chk("full_high_head", out_pri, 8);
    chk("full_high_data", out_data, 16'h0888);
    chk("full_high_cnt2", count, QD);
    tick();

    // Drain to 5 entries, then flush.
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    flush_req = 1'b1;
    #4;
    chk("flush_c0_count", count, 5);
    tick();
    flush_req = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      #4;
      chk($sformatf("flush_busy_c%0d", c), flush_busy, 1);
      chk($sformatf("flush_ovalid_c%0d", c), out_valid, 0);
      chk($sformatf("flush_ready_c%0d", c), req_ready, 0);
      chk($sformatf("flush_done_c%0d", c), flush_done, 0);
      tick();
    end
    req_valid = '0;
    #4;
    chk("flush_c7_busy", flush_busy, 0);
    chk("flush_c7_done", flush_done, 1);
    chk("flush_c7_count", count, 0);
    chk("flush_c7_ovalid", out_valid, 0);
    tick();
    #4;
    chk("flush_c8_done", flush_done, 0);
    tick();

    // Asynchronous reset in the middle of a flush.
    req_valid = '1;
    repeat (3) tick();
    req_valid = '0;
    out_ready = 1'b0;
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    repeat (2) tick();
    #2;
    rst = 1'b1;
    req_valid = '1;
    #1;
    chk("mid_rst_busy", flush_busy, 0);
    chk("mid_rst_done", flush_done, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_ovalid", out_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #4;
      chk($sformatf("post_rst_done%0d", c), flush_done, 0);
      chk($sformatf("post_rst_busy%0d", c), flush_busy, 0);
      tick();
    end
    req_valid = 4'b0001;
    req_pri[0] = 8'd1;
    req_data[0] = 16'h0111;
    #4;
    chk("post_rst_push", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    #4;
    chk("post_rst_ovalid", out_valid, 1);
    chk("post_rst_opri", out_pri, 1);
    chk("post_rst_count", count, 1);
    tick();

    // Randomized traffic against the reference model.
    reset_dut();
    mq.delete();
    rr = 0;
    m_fl = 1'b0;
    m_done = 1'b0;
    rv = '0;
    rp = '0;
    rd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!rv[i] && $urandom_range(0, 2) == 0) begin
          rv[i] = 1'b1;
          rp[i] = PW'($urandom_range(0, 7));
          rd[i] = DW'($urandom);
        end
      end
      req_valid = rv;
      req_pri   = rp;
      req_data  = rd;
      out_ready = ($urandom_range(0, 3) < ((cyc / 400) % 4));
      flush_req = ($urandom_range(0, 99) == 0);

      h = -1;
      for (int j = 0; j < mq.size(); j++) begin
        if (h < 0 || mq[j].pri > mq[h].pri) h = j;
      end
      m_pop = m_fl ? (mq.size() > 0) : (mq.size() > 0 && out_ready);
      g = -1;
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && rv[(rr + k) % NR]) g = (rr + k) % NR;
      end
      acc = !m_fl && g >= 0 && (mq.size() < QD || m_pop)
            && !(m_pop && rp[g] > mq[h].pri);
      e_ready = acc ? NR'(1 << g) : '0;

      #4;
      chk("rnd_ready", req_ready, e_ready);
      chk("rnd_ovalid", out_valid, !m_fl && mq.size() > 0);
      chk("rnd_count", count, mq.size());
      chk("rnd_busy", flush_busy, m_fl);
      chk("rnd_done", flush_done, m_done);
      if (!m_fl && mq.size() > 0) begin
        chk("rnd_opri", out_pri, mq[h].pri);
        chk("rnd_odata", out_data, mq[h].data);
      end

      nf = m_fl ? (mq.size() != 0) : flush_req;
      m_done = m_fl && mq.size() == 0;
      if (m_pop) mq.delete(h);
      if (acc) begin
        e.pri = rp[g];
        e.data = rd[g];
        mq.push_back(e);
        rr = (g + 1) % NR;
        rv[g] = 1'b0;
      end
      m_fl = nf;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
